// File: rtl/sa_pe_dot.sv
// Output-stationary systolic PE: LANES-wide dot-product MAC into one accumulator, with
// runtime signed/unsigned mode, optional saturation and a per-column drain shift chain.
module sa_pe_dot #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned LANES     = 4,
  parameter int unsigned ACC_WIDTH = 32,
  parameter bit          SAT       = 1'b1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  input  logic [LANES*IN_WIDTH-1:0]    i_a,
  input  logic [LANES*IN_WIDTH-1:0]    i_b,
  input  logic                         i_signed,
  input  logic                         i_clear,
  input  logic                         i_drain,
  input  logic [ACC_WIDTH-1:0]         i_c,
  input  logic                         i_c_valid,
  output logic [LANES*IN_WIDTH-1:0]    o_a,
  output logic [LANES*IN_WIDTH-1:0]    o_b,
  output logic                         o_valid,
  output logic                         o_signed,
  output logic                         o_clear,
  output logic                         o_drain,
  output logic [ACC_WIDTH-1:0]         o_c,
  output logic                         o_c_valid,
  output logic                         o_sat
);

  localparam int unsigned DW = LANES * IN_WIDTH;
  localparam int unsigned AW = ACC_WIDTH;
  // Internal sum width covers both the accumulator range and a full-beat product, so a
  // single beat larger than the accumulator still clamps/wraps correctly.
  localparam int unsigned PW = 2 * IN_WIDTH + $clog2(LANES) + 2;
  localparam int unsigned SW = ((AW + 1 > PW) ? AW + 1 : PW) + 1;

  localparam logic signed [SW-1:0] SMax = {{(SW-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMin = {{(SW-AW+1){1'b1}}, {(AW-1){1'b0}}};
  localparam logic signed [SW-1:0] UMax = {{(SW-AW){1'b0}}, {AW{1'b1}}};

  typedef enum logic [0:0] {StAcc, StShift} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic            valid_q, signed_q, clear_q, drain_q;
  logic [AW-1:0]   acc_q, acc_d, c_q, c_d;
  logic            c_valid_q, c_valid_d, sat_q, sat_d;

  logic signed [SW-1:0] prod_sum, base, sum;
  logic [AW-1:0]        acc_next;
  logic                 clamp;

  function automatic logic signed [SW-1:0] ext(input logic [IN_WIDTH-1:0] e, input logic s);
    ext = s ? {{(SW-IN_WIDTH){e[IN_WIDTH-1]}}, e} : {{(SW-IN_WIDTH){1'b0}}, e};
  endfunction

  always_comb begin
    prod_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      prod_sum = prod_sum + ext(i_a[i*IN_WIDTH +: IN_WIDTH], i_signed)
                          * ext(i_b[i*IN_WIDTH +: IN_WIDTH], i_signed);
    end
    if (i_clear || state_q == StShift) begin
      base = '0;
    end else begin
      base = i_signed ? {{(SW-AW){acc_q[AW-1]}}, acc_q} : {{(SW-AW){1'b0}}, acc_q};
    end
    sum      = base + prod_sum;
    acc_next = sum[AW-1:0];
    clamp    = 1'b0;
    if (SAT) begin
      if (i_signed) begin
        if (sum > SMax) begin
          acc_next = {1'b0, {(AW-1){1'b1}}};
          clamp    = 1'b1;
        end else if (sum < SMin) begin
          acc_next = {1'b1, {(AW-1){1'b0}}};
          clamp    = 1'b1;
        end
      end else begin
        if (sum[SW-1]) begin
          acc_next = '0;
          clamp    = 1'b1;
        end else if (sum > UMax) begin
          acc_next = '1;
          clamp    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = i_valid ? i_a : a_q;
    b_d       = i_valid ? i_b : b_q;
    acc_d     = acc_q;
    c_d       = c_q;
    c_valid_d = 1'b0;
    sat_d     = sat_q;

    if (i_valid) begin
      acc_d = acc_next;
    end else if (i_clear) begin
      acc_d = '0;
    end
    if (i_clear) begin
      sat_d = 1'b0;
    end

    unique case (state_q)
      StAcc: begin
        if (i_drain) begin
          c_d       = acc_d;
          c_valid_d = 1'b1;
          acc_d     = '0;
          sat_d     = 1'b0;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (i_drain) begin
          c_d       = i_c;
          c_valid_d = i_c_valid;
        end else begin
          state_d = StAcc;
        end
      end
    endcase

    // A saturation in this very cycle outranks any clear or capture.
    if (i_valid && clamp) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StAcc;
      a_q       <= '0;
      b_q       <= '0;
      valid_q   <= 1'b0;
      signed_q  <= 1'b0;
      clear_q   <= 1'b0;
      drain_q   <= 1'b0;
      acc_q     <= '0;
      c_q       <= '0;
      c_valid_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      valid_q   <= i_valid;
      signed_q  <= i_signed;
      clear_q   <= i_clear;
      drain_q   <= i_drain;
      acc_q     <= acc_d;
      c_q       <= c_d;
      c_valid_q <= c_valid_d;
      sat_q     <= sat_d;
    end
  end

  assign o_a       = a_q;
  assign o_b       = b_q;
  assign o_valid   = valid_q;
  assign o_signed  = signed_q;
  assign o_clear   = clear_q;
  assign o_drain   = drain_q;
  assign o_c       = c_q;
  assign o_c_valid = c_valid_q;
  assign o_sat     = sat_q;

endmodule

// File: tb/tb_sa_pe_dot.sv
// Scoreboard bench for sa_pe_dot: a 3-PE default column plus two 16-bit PEs
// (saturating and wrapping) fed the same stimulus.
module tb_sa_pe_dot;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   passed = 0;
  int   total  = 0;

  // Column of three default PEs, drain broadcast to all.
  logic [31:0] ca [3];
  logic [31:0] cb [3];
  logic        cv [3];
  logic        csg, cclr, cdrn;
  logic [31:0] oa [3];
  logic [31:0] ob [3];
  logic        ov [3], osg [3], oclr [3], odrn [3], osat [3];
  logic [31:0] col_c  [4];
  logic        col_cv [4];

  assign col_c[0]  = 32'd0;
  assign col_cv[0] = 1'b0;

  for (genvar g = 0; g < 3; g++) begin : g_col
    sa_pe_dot u_pe (
      .i_clk(clk), .i_rst(rst), .i_valid(cv[g]), .i_a(ca[g]), .i_b(cb[g]),
      .i_signed(csg), .i_clear(cclr), .i_drain(cdrn),
      .i_c(col_c[g]), .i_c_valid(col_cv[g]),
      .o_a(oa[g]), .o_b(ob[g]), .o_valid(ov[g]), .o_signed(osg[g]), .o_clear(oclr[g]),
      .o_drain(odrn[g]), .o_c(col_c[g+1]), .o_c_valid(col_cv[g+1]), .o_sat(osat[g])
    );
  end

  // 16-bit saturating and wrapping PEs sharing stimulus.
  logic [31:0] sa, sb;
  logic        sv, ssg, sclr, sdrn;
  logic [31:0] s_oa, s_ob, w_oa, w_ob;
  logic        s_ov, s_osg, s_oclr, s_odrn, w_ov, w_osg, w_oclr, w_odrn;
  logic [15:0] s_c, w_c;
  logic        s_cv, w_cv, s_sat, w_sat;

  sa_pe_dot #(.ACC_WIDTH(16), .SAT(1'b1)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_valid(sv), .i_a(sa), .i_b(sb), .i_signed(ssg),
    .i_clear(sclr), .i_drain(sdrn), .i_c(16'd0), .i_c_valid(1'b0),
    .o_a(s_oa), .o_b(s_ob), .o_valid(s_ov), .o_signed(s_osg), .o_clear(s_oclr),
    .o_drain(s_odrn), .o_c(s_c), .o_c_valid(s_cv), .o_sat(s_sat)
  );

  sa_pe_dot #(.ACC_WIDTH(16), .SAT(1'b0)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_valid(sv), .i_a(sa), .i_b(sb), .i_signed(ssg),
    .i_clear(sclr), .i_drain(sdrn), .i_c(16'd0), .i_c_valid(1'b0),
    .o_a(w_oa), .o_b(w_ob), .o_valid(w_ov), .o_signed(w_osg), .o_clear(w_oclr),
    .o_drain(w_odrn), .o_c(w_c), .o_c_valid(w_cv), .o_sat(w_sat)
  );

  logic [31:0] q_col  [$];
  logic [15:0] q_sat  [$];
  logic [15:0] q_wrap [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic logic [31:0] pk(input int e0, input int e1, input int e2, input int e3);
    return {e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every valid drain word is matched against the head of its queue.
  always @(negedge clk) begin
    if (col_cv[3] === 1'b1) begin
      if (q_col.size() == 0) begin
        total++;
        $display("FAIL col_unexpected: got %0h, want no output", col_c[3]);
      end else check("col_o_c", col_c[3], q_col.pop_front());
    end
    if (s_cv === 1'b1) begin
      if (q_sat.size() == 0) begin
        total++;
        $display("FAIL sat_unexpected: got %0h, want no output", s_c);
      end else check("sat_o_c", {16'd0, s_c}, {16'd0, q_sat.pop_front()});
    end
    if (w_cv === 1'b1) begin
      if (q_wrap.size() == 0) begin
        total++;
        $display("FAIL wrap_unexpected: got %0h, want no output", w_c);
      end else check("wrap_o_c", {16'd0, w_c}, {16'd0, q_wrap.pop_front()});
    end
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ca[i] = '0; cb[i] = '0; cv[i] = 1'b0;
    end
    csg = 0; cclr = 0; cdrn = 0;
    sa = '0; sb = '0; sv = 0; ssg = 0; sclr = 0; sdrn = 0;
    tick();
    tick();
    check("rst_o_c", col_c[3], 32'd0);
    check("rst_o_c_valid", {31'd0, col_cv[3]}, 32'd0);
    check("rst_o_a", oa[2], 32'd0);
    check("rst_o_sat", {31'd0, osat[2]}, 32'd0);
    check("rst_sat_o_c", {16'd0, s_c}, 32'd0);
    rst = 1'b0;
    tick();

    // Unsigned single beat: 1*5+2*6+3*7+4*8 = 70.
    ca[2] = pk(1, 2, 3, 4); cb[2] = pk(5, 6, 7, 8); cv[2] = 1; cclr = 1;
    tick();
    check("fwd_o_a", oa[2], pk(1, 2, 3, 4));
    check("fwd_o_valid", {31'd0, ov[2]}, 32'd1);
    check("fwd_o_clear", {31'd0, oclr[2]}, 32'd1);
    cv[2] = 0; cclr = 0; cdrn = 1; ca[2] = pk(9, 9, 9, 9);
    q_col.push_back(32'd70);
    tick();
    check("fwd_o_drain", {31'd0, odrn[2]}, 32'd1);
    check("hold_o_a", oa[2], pk(1, 2, 3, 4));
    check("fwd_o_valid_low", {31'd0, ov[2]}, 32'd0);
    cdrn = 0;
    tick();

    // Signed: 3 beats of 4*(-3*2) = -72.
    csg = 1; ca[2] = pk(-3, -3, -3, -3); cb[2] = pk(2, 2, 2, 2); cv[2] = 1; cclr = 1;
    tick();
    check("fwd_o_signed", {31'd0, osg[2]}, 32'd1);
    cclr = 0;
    tick();
    tick();
    cv[2] = 0; cdrn = 1;
    q_col.push_back(32'hFFFF_FFB8);
    tick();
    cdrn = 0;
    check("signed_no_sat", {31'd0, osat[2]}, 32'd0);
    tick();

    // Beat in the drain cycle is included: 70 + 4.
    csg = 0; ca[2] = pk(1, 2, 3, 4); cb[2] = pk(5, 6, 7, 8); cv[2] = 1; cclr = 1;
    tick();
    cclr = 0; ca[2] = pk(1, 1, 1, 1); cb[2] = pk(1, 1, 1, 1); cdrn = 1;
    q_col.push_back(32'd74);
    tick();
    cv[2] = 0; cdrn = 0;
    tick();

    // Column 10/20/30 drained bottom-first; PE2 starts a new tile during SHIFT.
    for (int i = 0; i < 3; i++) begin
      ca[i] = pk(10 * (i + 1), 0, 0, 0); cb[i] = pk(1, 0, 0, 0); cv[i] = 1;
    end
    cclr = 1;
    tick();
    for (int i = 0; i < 3; i++) cv[i] = 0;
    cclr = 0; cdrn = 1;
    q_col.push_back(32'd30); q_col.push_back(32'd20); q_col.push_back(32'd10);
    tick();
    cv[2] = 1; ca[2] = pk(5, 0, 0, 0);
    tick();
    cv[2] = 0;
    tick();
    cdrn = 0;
    tick();
    check("col_valid_drops", {31'd0, col_cv[3]}, 32'd0);
    check("col_o_c_holds", col_c[3], 32'd10);
    cv[2] = 1; ca[2] = pk(3, 0, 0, 0);
    tick();
    cv[2] = 0; cdrn = 1;
    q_col.push_back(32'd8);
    tick();
    cdrn = 0;
    tick();

    // Reset mid-drain, then a drain pulse captures the zeroed acc from ACC.
    ca[2] = pk(1, 2, 3, 4); cb[2] = pk(5, 6, 7, 8); cv[2] = 1; cclr = 1;
    tick();
    cv[2] = 0; cclr = 0; cdrn = 1;
    q_col.push_back(32'd70);
    tick();
    rst = 1;
    tick();
    check("mid_rst_o_c", col_c[3], 32'd0);
    check("mid_rst_o_c_valid", {31'd0, col_cv[3]}, 32'd0);
    check("mid_rst_o_drain", {31'd0, odrn[2]}, 32'd0);
    check("mid_rst_o_a", oa[2], 32'd0);
    rst = 0;
    q_col.push_back(32'd0);
    tick();
    cdrn = 0;
    tick();

    // 16-bit: 255*255*4 = 260100 saturates to 65535 or wraps to 63492.
    ssg = 0; sa = pk(255, 255, 255, 255); sb = pk(255, 255, 255, 255); sv = 1; sclr = 1;
    tick();
    check("sat_set", {31'd0, s_sat}, 32'd1);
    check("wrap_no_sat", {31'd0, w_sat}, 32'd0);
    sv = 0;
    tick();
    check("sat_clear_by_iclear", {31'd0, s_sat}, 32'd0);
    sclr = 0; sv = 1;
    tick();
    check("sat_set_again", {31'd0, s_sat}, 32'd1);
    sv = 0; sdrn = 1;
    q_sat.push_back(16'hFFFF);
    q_wrap.push_back(16'd63492);
    tick();
    check("sat_clear_by_drain", {31'd0, s_sat}, 32'd0);
    sdrn = 0;
    tick();

    // Signed: 4*(-128*127) = -65024 clamps to -32768 or wraps to 512.
    ssg = 1; sa = pk(-128, -128, -128, -128); sb = pk(127, 127, 127, 127); sv = 1; sclr = 1;
    tick();
    check("sat_signed_set", {31'd0, s_sat}, 32'd1);
    sv = 0; sclr = 0; sdrn = 1;
    q_sat.push_back(16'h8000);
    q_wrap.push_back(16'd512);
    tick();
    sdrn = 0;

    for (int i = 0; i < 20; i++) begin
      if (q_col.size() == 0 && q_sat.size() == 0 && q_wrap.size() == 0) break;
      tick();
    end
    tick();
    check("col_queue_empty", q_col.size(), 32'd0);
    check("sat_queue_empty", q_sat.size(), 32'd0);
    check("wrap_queue_empty", q_wrap.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
